// File: rtl/page_recycler_pkg.sv
// rtl/page_recycler_pkg.sv - shared defaults and FSM state encoding for the page recycler
package page_recycler_pkg;

  localparam int ADDR_W_DEF = 11;
  localparam int CNT_W_DEF  = 7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EMIT = 2'd1,
    ST_NEXT = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/page_recycler.sv
// rtl/page_recycler.sv - walks a packet's linked page chain, offering each page downstream
// and returning it to the null-page FIFO through a registered push stage.
module page_recycler
  import page_recycler_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_page,
  input  logic [CNT_W-1:0]  page_count,
  output logic              ptr_rd_en,
  output logic [ADDR_W-1:0] ptr_rd_addr,
  input  logic [ADDR_W-1:0] ptr_rd_data,
  output logic              rd_valid,
  output logic [ADDR_W-1:0] rd_page,
  input  logic              rd_ready,
  output logic              push_tail,
  output logic [ADDR_W-1:0] tail_addr,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   released_cnt
);

  state_t            state, state_nx;
  logic [ADDR_W-1:0] cur_page;
  logic [CNT_W-1:0]  remaining;
  logic              push_q;
  logic [ADDR_W-1:0] tail_q;
  logic              done_q;
  logic [ADDR_W:0]   cnt_q;
  logic              hs;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    rd_valid  = 1'b0;
    ptr_rd_en = 1'b0;
    busy      = 1'b1;
    hs        = 1'b0;
    case (state)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) state_nx = (page_count != '0) ? ST_EMIT : ST_DONE;
      end
      ST_EMIT: begin
        rd_valid  = 1'b1;
        ptr_rd_en = 1'b1;
        hs        = rd_ready;
        if (rd_ready) state_nx = (remaining == CNT_W'(1)) ? ST_DONE : ST_NEXT;
      end
      ST_NEXT: state_nx = ST_EMIT;
      ST_DONE: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // done is registered off ST_DONE, so it lands in the first IDLE cycle where busy is already low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_page  <= '0;
      remaining <= '0;
      push_q    <= 1'b0;
      tail_q    <= '0;
      done_q    <= 1'b0;
      cnt_q     <= '0;
    end else begin
      push_q <= 1'b0;
      done_q <= (state == ST_DONE);
      if (state == ST_IDLE && start) begin
        cur_page  <= start_page;
        remaining <= page_count;
      end
      if (hs) begin
        push_q    <= 1'b1;
        tail_q    <= cur_page;
        remaining <= remaining - 1'b1;
        cnt_q     <= cnt_q + 1'b1;
      end
      if (state == ST_NEXT) cur_page <= ptr_rd_data;
    end
  end

  assign rd_page      = cur_page;
  assign ptr_rd_addr  = cur_page;
  assign push_tail    = push_q;
  assign tail_addr    = tail_q;
  assign done         = done_q;
  assign released_cnt = cnt_q;

endmodule

// File: doc/page_recycler.md
PAGE_RECYCLER -- requirements
Module: page_recycler

Interface
REQ-001 Parameter ADDR_W, default 11, sets page-address width (2048 pages).
REQ-002 Parameter CNT_W, default 7, sets packet page-count width.
REQ-003 clk  input  1  single clock; all logic on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  one-cycle request to release a packet's page chain; honoured only while busy=0.
REQ-006 start_page  input  ADDR_W  first page of the chain; sampled with start.
REQ-007 page_count  input  CNT_W  number of pages in the chain; sampled with start.
REQ-008 ptr_rd_en  output  1  read strobe to the next-page pointer RAM.
REQ-009 ptr_rd_addr  output  ADDR_W  pointer RAM read address.
REQ-010 ptr_rd_data  input  ADDR_W  next-page pointer, valid exactly one cycle after ptr_rd_en.
REQ-011 rd_valid  output  1  current page offered to the downstream read engine.
REQ-012 rd_page  output  ADDR_W  page address offered; stable while rd_valid=1 and rd_ready=0.
REQ-013 rd_ready  input  1  downstream accepts the page when rd_valid&rd_ready.
REQ-014 push_tail  output  1  one-cycle pulse returning a freed page to the null-page FIFO.
REQ-015 tail_addr  output  ADDR_W  freed page address, valid with push_tail.
REQ-016 busy  output  1  high from the cycle after an accepted start until the cycle done pulses.
REQ-017 done  output  1  one-cycle pulse when the chain is fully released.
REQ-018 released_cnt  output  ADDR_W+1  total pages pushed since reset; wraps at 2^(ADDR_W+1).

Function
REQ-019 FSM states: IDLE, EMIT, NEXT, DONE.
REQ-020 IDLE: start=1 latches cur_page=start_page, remaining=page_count; goes to EMIT if page_count>0, else DONE.
REQ-021 EMIT: rd_valid=1, rd_page=cur_page, ptr_rd_en=1, ptr_rd_addr=cur_page, held every cycle until handshake.
REQ-022 EMIT handshake: next cycle push_tail=1, tail_addr=cur_page; remaining decrements; goes to DONE if remaining was 1, else NEXT.
REQ-023 NEXT: cur_page loads ptr_rd_data; ptr_rd_en=0, rd_valid=0; returns to EMIT next cycle.
REQ-024 Throughput: at most one page per two cycles; handshake-to-next rd_valid latency exactly 2 cycles.
REQ-025 DONE: done=1 for one cycle, busy=0 in the same cycle, then IDLE; start during DONE is ignored.
REQ-026 page_count=0: no rd_valid, no ptr read, no push; done pulses the second cycle after start.
REQ-027 push_tail is never asserted in two consecutive cycles; released_cnt increments by 1 per push.
REQ-028 Pointer wrap: page address 2^ADDR_W-1 and page 0 are legal chain members; no special handling.
REQ-029 rd_ready while rd_valid=0 is ignored; start while busy=1 is ignored and not queued.

Reset
REQ-030 rst_n low forces IDLE and sets rd_valid, push_tail, done, busy, ptr_rd_en to 0; rd_page, tail_addr, ptr_rd_addr to 0; released_cnt to 0.
REQ-031 Reset mid-chain abandons remaining pages without pushing them; a push registered before reset assertion is dropped if not yet presented.

Structure
REQ-032 Shared package holds ADDR_W, CNT_W defaults and the FSM state enum.
REQ-033 No sub-module; single flat module with a registered push stage.

Verification
REQ-034 start_page=5, page_count=3, pointers 5->9->12, rd_ready=1 -> rd_page 5,9,12; push_tail pulses tail_addr 5,9,12; done once; released_cnt=3.
REQ-035 Same chain, rd_ready low 4 cycles at page 9 -> rd_page holds 9, ptr_rd_addr holds 9, no extra push; total pushes 3.
REQ-036 page_count=0, start_page=7 -> no rd_valid, no push; done two cycles after start.
REQ-037 Chain 2047->0->1, page_count=3 -> tail_addr 2047,0,1 in order.
REQ-038 Second start while busy (start_page=20) -> ignored; only first chain's pages pushed.
REQ-039 rst_n low after first push of a 4-page chain -> outputs to reset values; released_cnt=0; no further pushes.
